// File: rtl/hex_disp_drv_if.sv
// hex_disp_drv_if: byte load strobe and multiplexed seven-segment outputs.
interface hex_disp_drv_if;
  logic [7:0] d_in;
  logic       load;
  logic [6:0] seg;
  logic       seg_Tg_out;
  logic       disp_valid;
  modport master (output d_in, load, input seg, seg_Tg_out, disp_valid);
  modport slave (input d_in, load, output seg, seg_Tg_out, disp_valid);
endinterface

// File: rtl/hex_disp_drv.sv
// hex_disp_drv: two-digit hex display driver with time-multiplexed digit select.
// Define HEX_DISP_BLANK_EN to blank a leading zero in the high digit.
module hex_disp_drv #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input logic           clk,
  input logic           rst,
  hex_disp_drv_if.slave bus
);
  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [6:0] LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic [7:0]   hold_q, hold_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic         sel_q, sel_d, valid_q, valid_d, wrap;
  logic [6:0]   seg_q, seg_d;
  logic [3:0]   nib;
  always_comb begin
    wrap    = cnt_q == W'(REFRESH_DIV - 1);
    cnt_d   = wrap ? '0 : cnt_q + W'(1);
    sel_d   = sel_q ^ wrap;
    hold_d  = bus.load ? bus.d_in : hold_q;
    valid_d = valid_q | bus.load;
    nib     = sel_q ? hold_q[7:4] : hold_q[3:0];
`ifdef HEX_DISP_BLANK_EN
    seg_d   = (sel_q && hold_q[7:4] == 4'h0) ? 7'h00 : LUT[nib];
`else
    seg_d   = LUT[nib];
`endif
  end
  // seg decodes the registered byte/select, so it lags a load or toggle by one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q  <= 8'h00;
      cnt_q   <= '0;
      sel_q   <= 1'b0;
      valid_q <= 1'b0;
      seg_q   <= 7'h3F;
    end else begin
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      seg_q   <= seg_d;
    end
  end
  assign bus.seg        = seg_q;
  assign bus.seg_Tg_out = sel_q;
  assign bus.disp_valid = valid_q;
endmodule

// File: tb/tb_hex_disp_drv.sv
// tb_hex_disp_drv: directed and random loads against a cycle-count based display model.
module tb_hex_disp_drv;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  hex_disp_drv_if bus ();
  hex_disp_drv #(.REFRESH_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int n_cmp = 0;
  int n_err = 0;
  int m_e;
  logic [7:0] m_hold;
  logic m_valid;
  logic [6:0] m_seg;
  function automatic logic sel_at(int e);
    return ((e / DIV) % 2) == 1;
  endfunction
  function automatic logic [6:0] shown(logic [7:0] b, logic s);
`ifdef HEX_DISP_BLANK_EN
    if (s && b[7:4] == 4'h0) return 7'h00;
`endif
    return s ? lut[b[7:4]] : lut[b[3:0]];
  endfunction
  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_e = 0;
    m_hold = 8'h00;
    m_valid = 1'b0;
    m_seg = 7'h3F;
  endtask
  task automatic cyc(logic ld, logic [7:0] d);
    bus.load = ld;
    bus.d_in = d;
    @(posedge clk);
    m_seg = shown(m_hold, sel_at(m_e));
    if (ld) m_hold = d;
    m_valid = m_valid | ld;
    m_e++;
    #1;
    chk("seg", {1'b0, bus.seg}, {1'b0, m_seg});
    chk("sel", {7'b0, bus.seg_Tg_out}, {7'b0, sel_at(m_e)});
    chk("valid", {7'b0, bus.disp_valid}, {7'b0, m_valid});
    bus.load = 1'b0;
  endtask
  task automatic chk_reset_state(string tag);
    chk({tag, "_seg"}, {1'b0, bus.seg}, 8'h3F);
    chk({tag, "_sel"}, {7'b0, bus.seg_Tg_out}, 8'h00);
    chk({tag, "_valid"}, {7'b0, bus.disp_valid}, 8'h00);
    chk({tag, "_hold"}, dut.hold_q, 8'h00);
  endtask
  initial begin
    bus.load = 1'b1;
    bus.d_in = 8'hEE;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    #2;
    rst = 1'b0;
    bus.load = 1'b0;
    model_reset();
    // idle: select toggles every DIV cycles, seg stays 3F
    repeat (12) cyc(1'b0, 8'h00);
    // A5 load, watch both digits
    cyc(1'b1, 8'hA5);
    repeat (10) cyc(1'b0, 8'h00);
    // same byte again must not change anything
    cyc(1'b1, 8'hA5);
    repeat (3) cyc(1'b0, 8'h00);
    // load 3C exactly on a wrap edge
    while ((m_e % DIV) != DIV - 1) cyc(1'b0, 8'h00);
    cyc(1'b1, 8'h3C);
    cyc(1'b0, 8'h00);
    chk("wrap_load_seg", {1'b0, bus.seg}, {1'b0, sel_at(m_e - 1) ? 7'h4F : 7'h39});
    repeat (6) cyc(1'b0, 8'h00);
    // leading zero in the high digit
    cyc(1'b1, 8'h07);
    repeat (10) cyc(1'b0, 8'h00);
    // async reset mid-dwell with load held high
    #2;
    rst = 1'b1;
    bus.load = 1'b1;
    bus.d_in = 8'hFF;
    #1;
    chk_reset_state("arst");
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("arst_hold");
    #2;
    rst = 1'b0;
    bus.load = 1'b0;
    model_reset();
    repeat (9) cyc(1'b0, 8'h00);
    // sweep every byte, one load per 9 cycles
    for (int b = 0; b < 256; b++) begin
      cyc(1'b1, 8'(b));
      repeat (8) cyc(1'b0, 8'h00);
    end
    // random back-to-back and sparse loads
    for (int i = 0; i < 400; i++) cyc(1'($urandom_range(0, 2) == 0), 8'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hex_disp_drv.md
HEX_DISP_DRV -- requirements
Module: hex_disp_drv

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clock cycles each digit is shown before the select toggles; legal range 2..2^24.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port d_in, input, 8 bits: byte to display, normally the memory block's d_out.
REQ-005 The block SHALL have port load, input, 1 bit: single-cycle strobe that captures d_in.
REQ-006 The block SHALL have port seg, output, 7 bits: active-high segments, seg[0]=a through seg[6]=g.
REQ-007 The block SHALL have port seg_Tg_out, output, 1 bit: digit select; 0 selects the low-nibble digit and 1 selects the high-nibble digit.
REQ-008 The block SHALL have port disp_valid, output, 1 bit: high once any byte has been loaded since reset.

Function
REQ-009 The block SHALL hold the byte in an 8-bit register hold_q; on a clk edge with load=1, hold_q takes d_in, otherwise it retains its value.
REQ-010 The prescaler SHALL count 0..REFRESH_DIV-1 every cycle, wrap to 0 after REFRESH_DIV-1, and use width $clog2(REFRESH_DIV).
REQ-011 seg_Tg_out SHALL be registered and SHALL toggle on the edge where the prescaler wraps, giving exactly REFRESH_DIV cycles per digit.
REQ-012 seg SHALL be registered and SHALL decode the nibble selected by the current hold_q and seg_Tg_out, so it reflects a load or select change one cycle later.
REQ-013 Hex decode SHALL be 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
REQ-014 A load and a prescaler wrap on the same edge SHALL both take effect; on the next edge seg shows the new byte's nibble for the new select.
REQ-015 Repeated loads SHALL overwrite hold_q each time and SHALL NOT disturb the prescaler or seg_Tg_out phase.
REQ-016 disp_valid SHALL go high on the edge after the first load and stay high until reset.
REQ-017 load with an unchanged d_in SHALL produce no visible change on seg.

Reset
REQ-018 With rst=1, regardless of clk, the following SHALL hold: hold_q=00, prescaler=0, seg_Tg_out=0, seg=3F, disp_valid=0.
REQ-019 A load asserted in the same cycle as rst SHALL be ignored.
REQ-020 After rst is released, the first prescaler wrap SHALL occur REFRESH_DIV edges later.
REQ-021 Reset asserted mid-digit SHALL abort the current dwell with no residual count.

Configuration
REQ-022 The macro HEX_DISP_BLANK_EN SHALL enable leading-zero blanking.
REQ-023 With HEX_DISP_BLANK_EN defined, seg SHALL be 00 while seg_Tg_out=1 and hold_q[7:4]=0; the low digit is never blanked.
REQ-024 Without HEX_DISP_BLANK_EN, both digits SHALL always be decoded per REQ-013; the macro SHALL NOT affect timing, ports or reset values.

Verification (REFRESH_DIV=4)
REQ-025 Reset, then release with no load -> seg=3F, seg_Tg_out toggles every 4 cycles, disp_valid=0 throughout.
REQ-026 load with d_in=A5 -> disp_valid=1; seg=6D when seg_Tg_out=0 and seg=77 when seg_Tg_out=1, each with one-cycle latency.
REQ-027 load with d_in=3C on a wrap edge -> the next cycle shows the new select's nibble of 3C (39 or 4F), with no stale A5 digit.
REQ-028 load with d_in=07 -> high digit seg=3F without HEX_DISP_BLANK_EN and seg=00 with it; the low digit is 07 in both builds.
REQ-029 Assert rst asynchronously mid-dwell with load=1 -> outputs are immediately 3F/0/0 and hold_q=00, and the first toggle comes 4 edges after release.
REQ-030 Sweep d_in over 00..FF with one load every 9 cycles -> each digit matches the REQ-013 table and the toggle period stays 4 cycles.
